// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: GMII receive preamble/SFD locator, FCS stripper and CRC32 checker
// with per-frame status reported alongside the last forwarded payload byte.
`default_nettype none

module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        phy_err,
    output logic [15:0] frame_len
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] MIN_L       = MIN_LEN;
    localparam logic [31:0] MAX_L       = MAX_LEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        phy_q;
    logic [7:0]  dly_q [5];
    logic        crc_bad;
    logic        len_bad;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_d   = crc_next(crc_q, rxd);
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        crc_bad = (crc_q != CRC_RESIDUE);
        len_bad = ({16'd0, cnt_q} < MIN_L) || ({16'd0, cnt_q} > MAX_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            crc_q      <= CRC_INIT;
            cnt_q      <= 16'd0;
            phy_q      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                dly_q[i] <= 8'd0;
            end
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
            frame_len  <= 16'd0;
        end else begin
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            frame_done <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (rx_dv) begin
                        state_q <= (rxd == 8'h55) ? S_PRE : S_DROP;
                    end
                end

                S_PRE: begin
                    if (!rx_dv) begin
                        state_q <= S_IDLE;
                    end else if (rxd == 8'hD5) begin
                        state_q <= S_DATA;
                        crc_q   <= CRC_INIT;
                        cnt_q   <= 16'd0;
                        phy_q   <= 1'b0;
                    end else if (rxd != 8'h55) begin
                        state_q <= S_DROP;
                    end
                end

                S_DATA: begin
                    if (rx_dv) begin
                        crc_q    <= crc_d;
                        cnt_q    <= cnt_d;
                        dly_q[0] <= rxd;
                        for (int i = 1; i < 5; i++) begin
                            dly_q[i] <= dly_q[i-1];
                        end
                        if (rx_er) begin
                            phy_q <= 1'b1;
                        end
                        // Oldest delayed byte is payload once five later bytes exist.
                        if (cnt_q >= 16'd5) begin
                            out_valid <= 1'b1;
                            out_data  <= dly_q[4];
                            out_sop   <= (cnt_q == 16'd5);
                        end
                    end else begin
                        state_q    <= S_IDLE;
                        frame_done <= 1'b1;
                        frame_len  <= cnt_q;
                        crc_err    <= crc_bad;
                        len_err    <= len_bad;
                        phy_err    <= phy_q;
                        frame_ok   <= !(crc_bad || len_bad || phy_q);
                        // Byte N-5 was held back so it can carry the end-of-frame mark.
                        if (cnt_q >= 16'd5) begin
                            out_valid <= 1'b1;
                            out_data  <= dly_q[4];
                            out_sop   <= (cnt_q == 16'd5);
                            out_eop   <= 1'b1;
                        end
                    end
                end

                S_DROP: begin
                    if (!rx_dv) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
Receive-side counterpart of the TX-path byte-wise CRC32 FCS generator. Takes the GMII-style 8-bit receive stream from the PHY interface and locates the preamble/SFD. It forwards the payload with the 4-byte FCS stripped, checks the FCS with an internal CRC32, and reports per-frame status (CRC, length, PHY error) on the last payload byte. Sits between the GMII RX register stage and the RX frame parser/FIFO.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes after SFD, FCS included
MAX_LEN, 1518, maximum legal frame length in bytes after SFD, FCS included

Ports:
clk  in  1  GMII RX clock
rst_n  in  1  asynchronous reset, active-low
rxd  in  8  receive byte from PHY
rx_dv  in  1  receive data valid; a byte is sampled on each clk edge where rx_dv=1
rx_er  in  1  PHY receive error
out_data  out  8  payload byte
out_valid  out  1  out_data valid this cycle
out_sop  out  1  first payload byte of frame, qualified by out_valid
out_eop  out  1  last payload byte of frame, qualified by out_valid
frame_done  out  1  one-cycle end-of-frame status strobe
frame_ok  out  1  valid with frame_done: no crc_err, len_err or phy_err
crc_err  out  1  valid with frame_done: FCS mismatch
len_err  out  1  valid with frame_done: length < MIN_LEN or > MAX_LEN
phy_err  out  1  valid with frame_done: rx_er seen during DATA
frame_len  out  16  valid with frame_done: byte count after SFD incl. FCS, saturating at 0xFFFF

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low. All outputs 0; FSM to IDLE; CRC register 0xFFFFFFFF; delay line and counters cleared. Reset mid-frame discards the frame and produces no frame_done.
- All outputs are registered.
- FSM states:
  - IDLE
    - rx_dv=1 and rxd=0x55 -> PREAMBLE.
    - rx_dv=1 and any other rxd, including 0xD5 -> DROP.
  - PREAMBLE
    - rx_dv=1, rxd=0x55 -> stay.
    - rx_dv=1, rxd=0xD5 -> DATA; CRC=0xFFFFFFFF, count=0, error flags cleared.
    - rx_dv=1, any other rxd -> DROP.
    - rx_dv=0 -> IDLE, no status.
  - DATA
    - Each sampled byte: update CRC, count++ (saturating), push into the 5-byte delay line.
    - rx_er=1 on any DATA cycle with rx_dv=1 sets phy_err_flag.
    - First edge with rx_dv=0 ends the frame -> IDLE.
  - DROP: no outputs; rx_dv=0 -> IDLE.
- CRC: reflected CRC-32, poly 0x04C11DB7 (reflected 0xEDB88320), bits LSB-first, init 0xFFFFFFFF. Computed over all N bytes after SFD, FCS included. The FCS is good iff the final register equals residue 0xDEBB20E3. One byte per clock, no throughput stall.
- Payload forwarding:
  - Byte k (0-based after SFD) is driven with out_valid=1 in the cycle after the edge sampling byte k+5.
  - At the frame-end edge, byte N-5 is driven with out_valid=1, out_eop=1.
  - out_sop=1 on byte 0; when N=5, out_sop and out_eop coincide.
  - The FCS bytes (N-4..N-1) are never output.
  - Throughput: one byte per cycle during a frame; out_valid is a continuous burst, except the final byte is held until the end edge.
- End of frame (cycle after the rx_dv=0 edge):
  - frame_done=1 and all status fields valid for one cycle, coincident with out_eop when N>=5.
  - N<5: no payload output, frame_done only; len_err=1, and crc_err=1 unless the residue check passes.
- Length rules:
  - len_err = (N < MIN_LEN) or (N > MAX_LEN).
  - Oversize frames are still received and forwarded to the end.
  - frame_len saturates at 0xFFFF.
- frame_ok = !crc_err && !len_err && !phy_err.
- Back-to-back frames: rx_dv may reassert on the edge immediately after the end edge; the new frame starts in IDLE with no loss.
- rx_er outside DATA is ignored.

Test Plan:
- 7x0x55, 0xD5, ASCII "123456789", FCS 0x26 0x39 0xF4 0xCB, MIN_LEN=64 -> 9 payload bytes 0x31..0x39 with sop on 0x31 and eop on 0x39; frame_done with frame_len=13, crc_err=0, len_err=1, frame_ok=0. With MIN_LEN=13: same stream, frame_ok=1.
- Same frame with last FCS byte 0xCA -> crc_err=1, frame_ok=0; payload still forwarded intact.
- 64-byte frame (60 zero bytes plus correct FCS 0x9C 0x6B 0x12 0x12... computed by bench model), rx_er pulsed on byte 20 -> 60 payload bytes; phy_err=1, crc_err=0, frame_ok=0, frame_len=64.
- Preamble 0x55 0x55 0x12 ... -> DROP: no out_valid and no frame_done until rx_dv falls. Next frame starting 1 cycle later is received correctly.
- Two back-to-back good 64-byte frames (rx_dv low for exactly one cycle between them) -> two frame_done pulses, each frame_ok=1; sop/eop correctly separated.
- rst_n asserted mid-payload of a 100-byte frame -> all outputs 0 immediately, no frame_done. After release, the next good frame reports frame_ok=1.
